// File: rtl/rk_pkg.sv
// Shared constants, FSM state encoding and saturation limits for the RK4 accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rk_pkg;

  localparam int N     = 32;
  localparam int FRAC  = 16;
  // Weighted sum of four N-bit slopes with weights 1,2,2,1 (total 6) needs 3 guard bits.
  localparam int ACC_W = N + 3;

  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_MUL  = 2'd2,
    ST_UPD  = 2'd3
  } state_t;

endpackage

// File: rtl/rk4_accum_if.sv
// Control, slope stream and result bundle between an RK4 slope source and rk4_accum.
// Latency: n/a (wires only).
// Backpressure: k_valid/k_ready handshake on the slope stream.
interface rk4_accum_if;

  logic                   start;
  logic                   init;
  logic [rk_pkg::N-1:0]   y_init;
  logic [rk_pkg::N-1:0]   h6;
  logic [rk_pkg::N-1:0]   k_in;
  logic                   k_valid;
  logic                   k_ready;
  logic                   abort;
  logic [rk_pkg::N-1:0]   y_out;
  logic                   y_sel;
  logic                   y_valid;
  logic                   busy;
  logic                   ovf;

  modport master (
    output start, init, y_init, h6, k_in, k_valid, abort,
    input  k_ready, y_out, y_sel, y_valid, busy, ovf
  );

  modport slave (
    input  start, init, y_init, h6, k_in, k_valid, abort,
    output k_ready, y_out, y_sel, y_valid, busy, ovf
  );

endinterface

// File: rtl/fx_mul_sat.sv
// Signed fixed-point multiply, arithmetic shift right by FRAC, saturate to N bits.
// Latency: combinational; the caller registers the result.
// Backpressure: none.
module fx_mul_sat #(
  parameter int N    = 32,
  parameter int FRAC = 16,
  parameter int AW   = 35
) (
  input  logic signed [AW-1:0] a_i,
  input  logic signed [N-1:0]  b_i,
  output logic        [N-1:0]  p_o,
  output logic                 sat_o
);

  localparam int PW = AW + N;

  logic signed [PW-1:0] prod_full;
  logic signed [PW-1:0] prod_shr;
  logic        [PW-N:0] upper;
  logic                 fits;

  assign prod_full = a_i * b_i;
  assign prod_shr  = prod_full >>> FRAC;

  // The shifted product fits in N bits when everything from bit N-1 upward is a sign copy.
  assign upper = prod_shr[PW-1:N-1];
  assign fits  = (&upper) | ~(|upper);

  // Clamp toward the sign of the full-width result when it does not fit.
  always_comb begin
    sat_o = ~fits;
    if (fits) begin
      p_o = prod_shr[N-1:0];
    end else if (prod_shr[PW-1]) begin
      p_o = {1'b1, {(N-1){1'b0}}};
    end else begin
      p_o = {1'b0, {(N-1){1'b1}}};
    end
  end

endmodule

// File: rtl/rk4_accum.sv
// One RK4 step: y += h/6 * (k1 + 2k2 + 2k3 + k4) with saturation and a sticky OVF flag.
// Latency: y_valid pulses 2 cycles after the edge that accepts k4.
// Backpressure: k_ready is high only in ACC; abort discards the step from any busy state.
module rk4_accum
  import rk_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  rk4_accum_if.slave bus
);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [1:0]        cnt_q, cnt_d;
  logic        [N-1:0]      prod_q, prod_d;
  logic        [N-1:0]      y_q, y_d;
  logic                     sel_q, sel_d;
  logic                     ovf_q, ovf_d;
  logic                     vld_q, vld_d;

  logic signed [ACC_W-1:0]  k_ext;
  logic signed [ACC_W-1:0]  k_wgt;
  logic        [N-1:0]      mul_p;
  logic                     mul_sat;
  logic        [N:0]        y_sum;
  logic                     upd_sat;
  logic        [N-1:0]      upd_y;

  // k2 and k3 carry weight 2; the counter tells which slope is arriving.
  assign k_ext = {{(ACC_W-N){bus.k_in[N-1]}}, bus.k_in};
  assign k_wgt = (cnt_q == 2'd1 || cnt_q == 2'd2) ? (k_ext <<< 1) : k_ext;

  fx_mul_sat #(
    .N    (N),
    .FRAC (FRAC),
    .AW   (ACC_W)
  ) u_mul (
    .a_i   (acc_q),
    .b_i   (bus.h6),
    .p_o   (mul_p),
    .sat_o (mul_sat)
  );

  // One guard bit on the update sum; a carry into it that differs from bit N-1 is overflow.
  assign y_sum   = {y_q[N-1], y_q} + {prod_q[N-1], prod_q};
  assign upd_sat = y_sum[N] ^ y_sum[N-1];
  assign upd_y   = upd_sat ? (y_sum[N] ? SAT_MIN : SAT_MAX) : y_sum[N-1:0];

  // Next-state and datapath updates; abort outranks every other action.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    y_d     = y_q;
    sel_d   = sel_q;
    ovf_d   = ovf_q;
    vld_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = ST_ACC;
          acc_d   = '0;
          cnt_d   = '0;
          if (bus.init) begin
            y_d   = bus.y_init;
            sel_d = 1'b0;
            ovf_d = 1'b0;
          end
        end
      end
      ST_ACC: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.k_valid) begin
          acc_d = acc_q + k_wgt;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          prod_d  = mul_p;
          ovf_d   = ovf_q | mul_sat;
          state_d = ST_UPD;
        end
      end
      ST_UPD: begin
        state_d = ST_IDLE;
        if (!bus.abort) begin
          y_d   = upd_y;
          ovf_d = ovf_q | upd_sat;
          sel_d = 1'b1;
          vld_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      y_q     <= '0;
      sel_q   <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.k_ready = (state_q == ST_ACC);
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.y_out   = y_q;
  assign bus.y_sel   = sel_q;
  assign bus.ovf     = ovf_q;
  assign bus.y_valid = vld_q;

endmodule

// File: tb/tb_rk4_accum.sv
// Randomised and directed RK4 steps against a plain-arithmetic model with a result scoreboard.
// Latency: expects each result 2 edges after the k4 acceptance edge.
// Backpressure: slopes are offered with random gaps and held until k_ready.
module tb_rk4_accum;

  localparam logic signed [127:0] LIM_HI = 128'sh7FFFFFFF;
  localparam logic signed [127:0] LIM_LO = -128'sh80000000;

  typedef struct {
    logic [31:0] y;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   ecount;
  exp_t sb[$];

  logic [31:0] y_m;
  logic        ovf_m;
  logic        sel_m;

  rk4_accum_if ifc ();

  rk4_accum dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecount++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat32(input logic signed [127:0] v, output logic o);
    o = 1'b0;
    if (v > LIM_HI) begin
      o = 1'b1;
      return 32'h7FFFFFFF;
    end
    if (v < LIM_LO) begin
      o = 1'b1;
      return 32'h80000000;
    end
    return v[31:0];
  endfunction

  function automatic logic signed [127:0] sx(input logic [31:0] v);
    return {{96{v[31]}}, v};
  endfunction

  // Monitor: every y_valid pulse must match the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ifc.y_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_y_valid", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("y_out", ifc.y_out, e.y);
          chk("ovf", ifc.ovf, e.ovf);
          chk("y_sel", ifc.y_sel, 1'b1);
          chk("latency", ecount, e.cyc);
        end
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // abort_after: index of the slope at which abort is raised instead (-1 = never).
  task automatic do_step(input logic init, input logic [31:0] yi, input logic [31:0] h,
                         input logic [31:0] k0, input logic [31:0] k1,
                         input logic [31:0] k2, input logic [31:0] k3,
                         input int gap_max, input int abort_after, input logic rst_in_mul);
    logic [31:0]         ks[4];
    logic signed [127:0] acc;
    logic signed [127:0] p;
    logic [31:0]         ps;
    logic [31:0]         ynew;
    logic                o1, o2;
    int                  acc_edge;
    int                  n;
    exp_t                e;
    ks[0] = k0; ks[1] = k1; ks[2] = k2; ks[3] = k3;
    acc_edge = 0;

    ifc.start  = 1'b1;
    ifc.init   = init;
    ifc.y_init = yi;
    ifc.h6     = h;
    ifc.k_valid = 1'b1;          // a slope offered in IDLE must be ignored
    ifc.k_in    = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    ifc.start   = 1'b0;
    ifc.k_valid = 1'b0;
    if (init) begin
      y_m   = yi;
      ovf_m = 1'b0;
      sel_m = 1'b0;
    end
    chk("busy_after_start", ifc.busy, 1'b1);
    chk("k_ready_in_acc", ifc.k_ready, 1'b1);
    chk("y_sel_after_start", ifc.y_sel, sel_m);
    chk("y_out_after_start", ifc.y_out, y_m);

    for (int i = 0; i < 4; i++) begin
      if (i == abort_after) begin
        ifc.abort   = 1'b1;
        ifc.k_valid = 1'b1;
        ifc.k_in    = 32'h1234_5678;
        @(posedge clk);
        #1;
        ifc.abort   = 1'b0;
        ifc.k_valid = 1'b0;
        chk("busy_after_abort", ifc.busy, 1'b0);
        chk("y_out_after_abort", ifc.y_out, y_m);
        chk("y_sel_after_abort", ifc.y_sel, sel_m);
        chk("ovf_after_abort", ifc.ovf, ovf_m);
        repeat (3) @(posedge clk);
        #1;
        return;
      end
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      ifc.k_valid = 1'b1;
      ifc.k_in    = ks[i];
      n = 0;
      while (!ifc.k_ready && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 20) chk("k_ready_timeout", 64'd1, 64'd0);
      acc_edge = ecount + 1;
      @(posedge clk);
      #1;
      ifc.k_valid = 1'b0;
    end

    // Now in the multiply stage: slopes and restarts here must be ignored.
    chk("k_ready_after_k4", ifc.k_ready, 1'b0);
    if (rst_in_mul) begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_y_out", ifc.y_out, 32'd0);
      chk("rst_y_sel", ifc.y_sel, 1'b0);
      chk("rst_y_valid", ifc.y_valid, 1'b0);
      chk("rst_k_ready", ifc.k_ready, 1'b0);
      chk("rst_busy", ifc.busy, 1'b0);
      chk("rst_ovf", ifc.ovf, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      y_m = '0; ovf_m = 1'b0; sel_m = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("no_busy_after_reset", ifc.busy, 1'b0);
      return;
    end

    acc  = sx(ks[0]) + 2 * sx(ks[1]) + 2 * sx(ks[2]) + sx(ks[3]);
    p    = (acc * sx(h)) >>> 16;
    ps   = sat32(p, o1);
    ynew = sat32(sx(y_m) + sx(ps), o2);
    y_m   = ynew;
    ovf_m = ovf_m | o1 | o2;
    sel_m = 1'b1;
    e.y   = y_m;
    e.ovf = ovf_m;
    e.cyc = acc_edge + 2;
    sb.push_back(e);

    ifc.start   = 1'b1;
    ifc.init    = 1'b1;
    ifc.y_init  = 32'h5555_5555;
    ifc.k_valid = 1'b1;
    ifc.k_in    = 32'h7FFF_FFFF;
    @(posedge clk);
    #1;
    ifc.start   = 1'b0;
    ifc.k_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    int k[4];
    int hv;
    logic [31:0] yi;
    checks = 0;
    errors = 0;
    ecount = 0;
    y_m = '0; ovf_m = 1'b0; sel_m = 1'b0;
    rst_n       = 1'b0;
    ifc.start   = 1'b0;
    ifc.init    = 1'b0;
    ifc.y_init  = '0;
    ifc.h6      = '0;
    ifc.k_in    = '0;
    ifc.k_valid = 1'b0;
    ifc.abort   = 1'b0;
    #12;
    chk("reset_y_out", ifc.y_out, 32'd0);
    chk("reset_y_sel", ifc.y_sel, 1'b0);
    chk("reset_y_valid", ifc.y_valid, 1'b0);
    chk("reset_k_ready", ifc.k_ready, 1'b0);
    chk("reset_busy", ifc.busy, 1'b0);
    chk("reset_ovf", ifc.ovf, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Abort together with start in IDLE: start is dropped.
    ifc.start = 1'b1; ifc.abort = 1'b1; ifc.init = 1'b1; ifc.y_init = 32'h0000_1111;
    @(posedge clk);
    #1;
    ifc.start = 1'b0; ifc.abort = 1'b0;
    chk("start_abort_idle_busy", ifc.busy, 1'b0);
    chk("start_abort_idle_y", ifc.y_out, 32'd0);

    do_step(1'b1, 32'h0001_0000, 32'h0000_2AAB, 32'h10000, 32'h10000, 32'h10000, 32'h10000, 0, -1, 1'b0);
    chk("init_step_y", ifc.y_out, 32'h0002_0002);
    chk("init_step_ovf", ifc.ovf, 1'b0);
    do_step(1'b0, 32'h0, 32'h0000_2AAB, 32'h10000, 32'h10000, 32'h10000, 32'h10000, 0, -1, 1'b0);
    chk("second_step_y", ifc.y_out, 32'h0003_0004);
    chk("second_step_sel", ifc.y_sel, 1'b1);

    do_step(1'b1, 32'h7FFF_0000, 32'h0001_0000, 32'h10000, 32'h10000, 32'h10000, 32'h10000, 0, -1, 1'b0);
    chk("sat_step_y", ifc.y_out, 32'h7FFF_FFFF);
    chk("sat_step_ovf", ifc.ovf, 1'b1);
    do_step(1'b1, 32'h0001_0000, 32'h0000_2AAB, 32'h10000, 32'h10000, 32'h10000, 32'h10000, 3, -1, 1'b0);
    chk("gapped_init_y", ifc.y_out, 32'h0002_0002);
    chk("ovf_cleared_by_init", ifc.ovf, 1'b0);

    do_step(1'b0, 32'h0, 32'h0000_2AAB, 32'h10000, 32'h10000, 32'h10000, 32'h10000, 0, 2, 1'b0);
    chk("abort_keeps_y", ifc.y_out, 32'h0002_0002);
    do_step(1'b0, 32'h0, 32'h0000_2AAB, 32'h10000, 32'h10000, 32'h10000, 32'h10000, 0, -1, 1'b0);
    chk("after_abort_y", ifc.y_out, 32'h0003_0004);

    do_step(1'b0, 32'h0, 32'h0000_2AAB, 32'h10000, 32'h10000, 32'h10000, 32'h10000, 1, -1, 1'b1);
    chk("reset_in_mul_y", ifc.y_out, 32'd0);

    for (int s = 0; s < 40; s++) begin
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 7) == 0) k[j] = int'($urandom());
        else k[j] = int'($urandom_range(0, 4194303)) - 2097152;
      end
      if ($urandom_range(0, 5) == 0) hv = int'($urandom());
      else hv = int'($urandom_range(0, 262143)) - 131072;
      yi = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() >> 8);
      do_step(($urandom_range(0, 3) == 0), yi, hv, k[0], k[1], k[2], k[3],
              3, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1, 1'b0);
      chk("rand_y", ifc.y_out, y_m);
      chk("rand_ovf", ifc.ovf, ovf_m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rk4_accum.md
RK4_ACCUM -- requirements
Module: rk4_accum

Interface
REQ-001 Parameter N, 32, data width in bits; all data ports are signed two's complement.
REQ-002 Parameter FRAC, 16, fractional bits of the Q(N-FRAC).FRAC fixed-point format.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 START  input  1  single-cycle pulse that begins one RK4 step; honoured only in IDLE.
REQ-007 INIT  input  1  sampled with START; 1 = load Y_INIT into the state register first.
REQ-008 Y_INIT  input  N  initial condition y0.
REQ-009 H6  input  N  step size divided by 6 (h/6), Q format; held stable during a step.
REQ-010 K_IN  input  N  slope value k1..k4, supplied in order.
REQ-011 K_VALID  input  1  K_IN is valid.
REQ-012 K_READY  output  1  block accepts K_IN this cycle.
REQ-013 ABORT  input  1  discard the step in progress.
REQ-014 Y_OUT  output  N  current state y_n; feeds IN_1 of the downstream 2:1 select mux.
REQ-015 Y_SEL  output  1  select for the downstream mux: 0 = Y_INIT path, 1 = Y_OUT feedback.
REQ-016 Y_VALID  output  1  one-cycle pulse when Y_OUT holds a new y_{n+1}.
REQ-017 BUSY  output  1  high in every state other than IDLE.
REQ-018 OVF  output  1  sticky saturation flag.

Function
REQ-019 FSM states SHALL be IDLE, ACC, MUL and UPD.
REQ-020 IDLE: K_READY=0; on START go to ACC, clear accumulator and k counter; if INIT=1, also load Y_OUT<=Y_INIT, clear Y_SEL and clear OVF.
REQ-021 ACC: K_READY=1; a k is accepted only on K_VALID&&K_READY; 2-bit counter counts 0..3.
REQ-022 Weights SHALL be 1,2,2,1 for k1..k4 (k2 and k3 left-shifted by 1); accumulator is N+3 bits signed, never overflows.
REQ-023 Acceptance of the 4th k SHALL move to MUL on the next edge; K_READY deasserts in that cycle.
REQ-024 MUL: register product = acc * H6, full width, arithmetic shift right FRAC, saturate to N bits signed; saturation sets OVF.
REQ-025 UPD: Y_OUT <= saturating sum of Y_OUT and scaled product; saturation sets OVF; Y_SEL<=1; Y_VALID=1 for one cycle after that edge; return to IDLE.
REQ-026 Latency: Y_VALID SHALL be asserted exactly 2 cycles after the edge that accepted k4.
REQ-027 START outside IDLE and K_VALID outside ACC SHALL be ignored.
REQ-028 ABORT in ACC, MUL or UPD SHALL return to IDLE on the next edge; Y_OUT, Y_SEL and OVF unchanged; no Y_VALID. ABORT has priority over k acceptance and update.
REQ-029 START and ABORT together in IDLE: ABORT wins, START ignored.
REQ-030 OVF SHALL clear only on reset or START with INIT=1.
REQ-031 Saturation limits: 2^(N-1)-1 and -2^(N-1).

Reset
REQ-032 RST_N low SHALL immediately force state IDLE; Y_OUT=0, Y_SEL=0, Y_VALID=0, K_READY=0, BUSY=0, OVF=0; accumulator and counter 0.
REQ-033 Reset mid-step SHALL discard the step; no Y_VALID after release.

Structure
REQ-034 Package rk_pkg SHALL hold N, FRAC, the FSM state enum and saturation limit constants.
REQ-035 One sub-module fx_mul_sat (Q multiply, shift, saturate) SHALL be used for the MUL stage.

Verification
REQ-036 INIT step: Y_INIT=0x00010000, H6=0x00002AAB, k1..k4=0x00010000 -> Y_OUT=0x00020002, Y_SEL=1, OVF=0, Y_VALID 2 cycles after k4.
REQ-037 Saturation: Y_INIT=0x7FFF0000, H6=0x00010000, all k=0x00010000 -> Y_OUT=0x7FFFFFFF, OVF=1; next INIT step clears OVF.
REQ-038 Gapped K_VALID (k accepted on cycles 1,4,5,9) -> identical result to back-to-back, Y_VALID 2 cycles after cycle-9 edge.
REQ-039 ABORT after 2 k's -> IDLE next cycle, Y_OUT unchanged, no Y_VALID; a following START without INIT runs normally from old Y_OUT.
REQ-040 RST_N asserted in MUL -> all outputs at reset values asynchronously, no Y_VALID after release.
REQ-041 Second step without INIT after REQ-036 (same k, H6) -> Y_OUT=0x00030004, Y_SEL stays 1.
